// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl
//   Programmable timer controller: sequences a W-bit up-counter with
//   start / stop / hold control, one-shot or auto-reload operation and a
//   registered one-cycle terminal-count strobe.
//
//   The counter runs 0..period_r. In one-shot mode it parks in DONE with
//   count == period_r. In auto-reload mode it wraps to 0 and keeps running.
//
//   Optional build macro: TIMER_PRESCALE_EN
//     When defined, adds input prescale[7:0] and an 8-bit prescale counter.
//     Each count step then takes prescale+1 RUN cycles.
//     When undefined, the count steps on every RUN cycle.
// -----------------------------------------------------------------------------
module timer_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         res,
    input  logic         cfg_load,
    input  logic [W-1:0] cfg_period,
    input  logic         cfg_auto,
    input  logic         start,
    input  logic         stop,
    input  logic         hold,
`ifdef TIMER_PRESCALE_EN
    input  logic [7:0]   prescale,
`endif
    output logic [W-1:0] count,
    output logic         tc_pulse,
    output logic         busy,
    output logic         done
);

    // State encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [W-1:0] ZERO_W = {W{1'b0}};
    localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};

    // Registered state
    logic [1:0]   state_r;
    logic [W-1:0] count_r;
    logic         tc_r;
    logic [W-1:0] period_r;
    logic         auto_r;
    logic         busy_r;
    logic         done_r;
    logic [7:0]   psc_r;

    // Next-state values
    logic [1:0]   state_nxt_s;
    logic [W-1:0] count_nxt_s;
    logic         tc_nxt_s;
    logic [W-1:0] period_nxt_s;
    logic         auto_nxt_s;
    logic [7:0]   psc_nxt_s;

    // Step enable and prescaler helpers
    logic         tick_s;
    logic         at_tc_s;
    logic         cfg_open_s;

    // Terminal value reached by the current count
    assign at_tc_s = (count_r == period_r);

    // Configuration is only writable while the timer is not busy
    assign cfg_open_s = (state_r == ST_IDLE) || (state_r == ST_DONE);

`ifdef TIMER_PRESCALE_EN
    // A count step is allowed when the prescale counter matches the live divisor
    always_comb begin
        tick_s = (psc_r == prescale);
    end
`else
    // Without a prescaler every RUN cycle is a count step
    always_comb begin
        tick_s = 1'b1;
    end
`endif

    // Configuration register next values
    always_comb begin
        period_nxt_s = period_r;
        auto_nxt_s   = auto_r;
        if (cfg_load && cfg_open_s) begin
            period_nxt_s = cfg_period;
            auto_nxt_s   = cfg_auto;
        end else begin
            period_nxt_s = period_r;
            auto_nxt_s   = auto_r;
        end
    end

    // Control FSM: priority stop > start > hold > counting
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        tc_nxt_s    = 1'b0;
        psc_nxt_s   = psc_r;
        case (state_r)
            ST_IDLE: begin
                if (stop) begin
                    // Stop in IDLE has no effect; keep the parked values
                    state_nxt_s = ST_IDLE;
                end else if (start) begin
                    state_nxt_s = ST_RUN;
                    count_nxt_s = ZERO_W;
                    psc_nxt_s   = 8'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                    count_nxt_s = ZERO_W;
                    psc_nxt_s   = 8'd0;
                end else if (start) begin
                    // Restart overrides hold on the same edge
                    state_nxt_s = ST_RUN;
                    count_nxt_s = ZERO_W;
                    psc_nxt_s   = 8'd0;
                end else if (hold) begin
                    // Freeze; no terminal check on the entering cycle
                    state_nxt_s = ST_HOLD;
                end else if (tick_s) begin
                    psc_nxt_s = 8'd0;
                    if (at_tc_s) begin
                        tc_nxt_s = 1'b1;
                        if (auto_r) begin
                            state_nxt_s = ST_RUN;
                            count_nxt_s = ZERO_W;
                        end else begin
                            // One-shot parks with count == period_r
                            state_nxt_s = ST_DONE;
                        end
                    end else begin
                        count_nxt_s = count_r + ONE_W;
                    end
                end else begin
                    // Waiting for the prescaler to reach its divisor
                    psc_nxt_s = psc_r + 8'd1;
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                    count_nxt_s = ZERO_W;
                    psc_nxt_s   = 8'd0;
                end else if (start) begin
                    state_nxt_s = ST_RUN;
                    count_nxt_s = ZERO_W;
                    psc_nxt_s   = 8'd0;
                end else if (!hold) begin
                    // Resume; count is unchanged on the release cycle
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_DONE: begin
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                    count_nxt_s = ZERO_W;
                    psc_nxt_s   = 8'd0;
                end else if (start) begin
                    state_nxt_s = ST_RUN;
                    count_nxt_s = ZERO_W;
                    psc_nxt_s   = 8'd0;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                // Unreachable encoding: fall back to a safe parked state
                state_nxt_s = ST_IDLE;
                count_nxt_s = ZERO_W;
                psc_nxt_s   = 8'd0;
            end
        endcase
    end

    // State, datapath and configuration registers with synchronous reset
    always_ff @(posedge clk) begin
        if (res) begin
            state_r  <= ST_IDLE;
            count_r  <= ZERO_W;
            tc_r     <= 1'b0;
            period_r <= ZERO_W;
            auto_r   <= 1'b0;
            psc_r    <= 8'd0;
        end else begin
            state_r  <= state_nxt_s;
            count_r  <= count_nxt_s;
            tc_r     <= tc_nxt_s;
            period_r <= period_nxt_s;
            auto_r   <= auto_nxt_s;
            psc_r    <= psc_nxt_s;
        end
    end

    // Status flags registered alongside the state so they track it glitch-free
    always_ff @(posedge clk) begin
        if (res) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_HOLD);
            done_r <= (state_nxt_s == ST_DONE);
        end
    end

    assign count    = count_r;
    assign tc_pulse = tc_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_ctrl
//   Directed self-checking bench for timer_ctrl: a table of single-edge
//   vectors followed by hand-written multi-cycle sequences.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_timer_ctrl;

    logic       clk;
    logic       res;
    logic       cfg_load;
    logic [7:0] cfg_period;
    logic       cfg_auto;
    logic       start;
    logic       stop;
    logic       hold;
`ifdef TIMER_PRESCALE_EN
    logic [7:0] prescale;
`endif
    logic [7:0] count;
    logic       tc_pulse;
    logic       busy;
    logic       done;

    int n_assert;
    int n_fail;

    timer_ctrl #(.W(8)) dut (
        .clk        (clk),
        .res        (res),
        .cfg_load   (cfg_load),
        .cfg_period (cfg_period),
        .cfg_auto   (cfg_auto),
        .start      (start),
        .stop       (stop),
        .hold       (hold),
`ifdef TIMER_PRESCALE_EN
        .prescale   (prescale),
`endif
        .count      (count),
        .tc_pulse   (tc_pulse),
        .busy       (busy),
        .done       (done)
    );

    // Free-running clock, 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       ld;
        logic [7:0] per;
        logic       ar;
        logic       st;
        logic       sp;
        logic       hd;
        logic [7:0] e_count;
        logic       e_tc;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, ld, input logic [7:0] per,
                                input logic ar, st, sp, hd,
                                input logic [7:0] ec, input logic et, eb, ed);
        vec_t v;
        v.r = r; v.ld = ld; v.per = per; v.ar = ar;
        v.st = st; v.sp = sp; v.hd = hd;
        v.e_count = ec; v.e_tc = et; v.e_busy = eb; v.e_done = ed;
        return v;
    endfunction

    task automatic drive(input logic r, ld, input logic [7:0] per,
                         input logic ar, st, sp, hd);
        res = r; cfg_load = ld; cfg_period = per; cfg_auto = ar;
        start = st; stop = sp; hold = hd;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance one active edge and settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] ec,
                       input logic et, eb, ed);
        n_assert += 4;
        if (count !== ec) begin
            n_fail++;
            $display("FAIL %s count: got %0d expected %0d", nm, count, ec);
        end
        if (tc_pulse !== et) begin
            n_fail++;
            $display("FAIL %s tc_pulse: got %0b expected %0b", nm, tc_pulse, et);
        end
        if (busy !== eb) begin
            n_fail++;
            $display("FAIL %s busy: got %0b expected %0b", nm, busy, eb);
        end
        if (done !== ed) begin
            n_fail++;
            $display("FAIL %s done: got %0b expected %0b", nm, done, ed);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
`ifdef TIMER_PRESCALE_EN
        prescale = 8'd0;
`endif
        drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // ---------------- table: r ld per ar st sp hd | count tc busy done
        // reset, then one-shot period 5
        vecs.push_back(mk(1, 0, 8'd0, 0, 0, 0, 0, 8'd0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 8'd0, 0, 0, 0, 0, 8'd0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'd5, 0, 0, 0, 0, 8'd0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0, 0, 1, 0, 0, 8'd0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0, 0, 0, 0, 0, 8'd1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0, 0, 0, 0, 0, 8'd2, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0, 0, 0, 0, 0, 8'd3, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0, 0, 0, 0, 0, 8'd4, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0, 0, 0, 0, 0, 8'd5, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0, 0, 0, 0, 0, 8'd5, 1, 0, 1));
        vecs.push_back(mk(0, 0, 8'd0, 0, 0, 0, 0, 8'd5, 0, 0, 1));
        // stop from DONE, then stop in IDLE is a no-op
        vecs.push_back(mk(0, 0, 8'd0, 0, 0, 1, 0, 8'd0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0, 0, 0, 1, 0, 8'd0, 0, 0, 0));
        // stop wins over terminal count (period 2)
        vecs.push_back(mk(0, 1, 8'd2, 0, 0, 0, 0, 8'd0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0, 0, 1, 0, 0, 8'd0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0, 0, 0, 0, 0, 8'd1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0, 0, 0, 0, 0, 8'd2, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0, 0, 0, 1, 0, 8'd0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0, 0, 0, 0, 0, 8'd0, 0, 0, 0));
        // period 0 one-shot: tc one cycle after start
        vecs.push_back(mk(0, 1, 8'd0, 0, 0, 0, 0, 8'd0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'd0, 0, 1, 0, 0, 8'd0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0, 0, 0, 0, 0, 8'd0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 8'd0, 0, 0, 0, 0, 8'd0, 0, 0, 1));
        // cfg accepted in DONE: period 0 auto gives tc every cycle
        vecs.push_back(mk(0, 1, 8'd0, 1, 0, 0, 0, 8'd0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'd0, 0, 1, 0, 0, 8'd0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0, 0, 0, 0, 0, 8'd0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0, 0, 0, 0, 0, 8'd0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 8'd0, 0, 0, 1, 0, 8'd0, 0, 0, 0));
        // reset overrides start
        vecs.push_back(mk(1, 1, 8'd7, 1, 1, 0, 0, 8'd0, 0, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].ld, vecs[i].per, vecs[i].ar,
                  vecs[i].st, vecs[i].sp, vecs[i].hd);
            tick();
            chk($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_tc,
                vecs[i].e_busy, vecs[i].e_done);
        end

        // ---------------- auto-reload period 3, 20 cycles
        drive(1'b0, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        chk("auto_start", 8'd0, 1'b0, 1'b1, 1'b0);
        idle_in();
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk($sformatf("auto_E%0d", k), 8'(k % 4), (k % 4) == 0, 1'b1, 1'b0);
        end
        drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        chk("auto_stop", 8'd0, 1'b0, 1'b0, 1'b0);

        // ---------------- hold at count 3, period 10 one-shot
        drive(1'b0, 1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        chk("hold_start", 8'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            logic [7:0] ec;
            drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, (k >= 4 && k <= 6));
            tick();
            if (k <= 3)       ec = 8'(k);
            else if (k <= 7)  ec = 8'd3;
            else if (k <= 14) ec = 8'(k - 4);
            else              ec = 8'd10;
            chk($sformatf("hold_E%0d", k), ec, k == 15, k < 15, k >= 15);
        end

        // ---------------- config lockout and mid-run restart
        drive(1'b0, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        chk("lock_start", 8'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            drive(1'b0, (k == 2), 8'd9, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
            chk($sformatf("lock_E%0d", k), (k <= 4) ? 8'(k) : 8'd4,
                k == 5, k < 5, k >= 5);
        end
        drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        idle_in(); tick(); tick();
        chk("restart_pre", 8'd2, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        chk("restart_E", 8'd0, 1'b0, 1'b1, 1'b0);
        idle_in(); tick();
        chk("restart_E1", 8'd1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0); tick();

        // ---------------- period 255 auto: tc every 256 cycles
        drive(1'b0, 1'b1, 8'd255, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        idle_in();
        for (int k = 1; k <= 512; k++) begin
            tick();
            if (k == 255 || k == 256 || k == 257 || k == 511 || k == 512)
                chk($sformatf("p255_E%0d", k), 8'(k % 256), (k % 256) == 0,
                    1'b1, 1'b0);
            else begin
                n_assert++;
                if (tc_pulse !== 1'b0) begin
                    n_fail++;
                    $display("FAIL p255_E%0d tc_pulse: got %0b expected 0", k, tc_pulse);
                end
            end
        end
        drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0); tick();

`ifdef TIMER_PRESCALE_EN
        // ---------------- prescale 2, period 1 one-shot: tc at E6
        prescale = 8'd2;
        drive(1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        idle_in();
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("psc_E%0d", k), (k >= 3) ? 8'd1 : 8'd0,
                k == 6, k < 6, k >= 6);
        end
        prescale = 8'd0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
